// File: rtl/latch_loader_pkg.sv
// Shared state encoding and counter-width helpers for the serial latch loader.
package latch_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold n-1, never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag, shared by the setup/strobe/hold phases.
module cycle_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/serial_latch_loader.sv
// Serial-to-parallel front end that drives a transparent latch bank with a
// setup / strobe / hold enable sequence around a stable data word.
module serial_latch_loader
    import latch_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sdi,
    input  logic             sdi_valid,
    output logic             sdi_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] d_out,
    output logic             en_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned TMR_W = cnt_width(max3(SETUP_CYC, EN_CYC, HOLD_CYC));

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   bitcnt;
    logic [WIDTH-1:0]   shift_next;
    logic               take;
    logic               last_bit;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    assign sdi_ready = (state == ST_IDLE) || (state == ST_SHIFT);
    assign busy      = (state != ST_IDLE);
    assign take      = sdi_valid && sdi_ready && !abort;
    assign last_bit  = (state == ST_IDLE) ? (WIDTH == 1)
                                          : (bitcnt == CNT_W'(WIDTH - 1));

    // Shift value: a fresh frame starts from the LSB, later bits shift in MSB first.
    if (WIDTH == 1) begin : gen_w1
        assign shift_next = sdi;
    end else begin : gen_wn
        assign shift_next = (state == ST_SHIFT) ? {shreg[WIDTH-2:0], sdi}
                                                : {{(WIDTH-1){1'b0}}, sdi};
    end

    // Timer reload values, issued on the transition into each timed phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE, ST_SHIFT: begin
                if (take && last_bit) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(EN_CYC - 1);
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYC - 1);
                end
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Frame assembly and latch strobe sequencing; d_out only moves when a frame completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            d_out  <= '0;
            en_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        shreg  <= '0;
                        bitcnt <= '0;
                    end else if (take) begin
                        shreg <= shift_next;
                        if (last_bit) begin
                            d_out  <= shift_next;
                            bitcnt <= '0;
                            state  <= ST_SETUP;
                        end else begin
                            bitcnt <= (state == ST_SHIFT) ? bitcnt + CNT_W'(1) : CNT_W'(1);
                            state  <= ST_SHIFT;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        state  <= ST_STROBE;
                        en_out <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (tmr_zero) begin
                        state  <= ST_HOLD;
                        en_out <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    en_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_latch_loader.sv
// Scoreboard bench for serial_latch_loader: the driver records each completed
// frame and its last-accept edge, the monitor checks every strobe against that.
module tb_serial_latch_loader;

    localparam int W  = 8;
    localparam int SC = 2;
    localparam int EC = 3;
    localparam int HC = 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         sdi;
    logic         sdi_valid;
    logic         sdi_ready;
    logic         abort;
    logic [W-1:0] d_out;
    logic         en_out;
    logic         busy;
    logic         done;

    serial_latch_loader #(
        .WIDTH     (W),
        .SETUP_CYC (SC),
        .EN_CYC    (EC),
        .HOLD_CYC  (HC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sdi       (sdi),
        .sdi_valid (sdi_valid),
        .sdi_ready (sdi_ready),
        .abort     (abort),
        .d_out     (d_out),
        .en_out    (en_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        int           t_last;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    int   strobe_cnt = 0;
    int   rise_cyc = 0;
    bit   active = 1'b0;
    bit   en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    // Send the top nbits of word MSB first; a full frame is pushed to the scoreboard.
    task automatic send_bits(input logic [W-1:0] word, input int nbits,
                             input bit rand_valid, output int t_last);
        int k = 0;
        int guard = 0;
        t_last = -1;
        while (k < nbits && guard < 400) begin
            @(negedge clk);
            sdi       = word[W-1-k];
            sdi_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sdi_valid && sdi_ready && !abort) begin
                t_last = cyc + 1;
                k++;
            end
            guard++;
        end
        check("send_timeout", k, nbits);
        if (nbits == W && k == nbits) begin
            cur.word   = word;
            cur.t_last = t_last;
            exp_q.push_back(cur);
        end
    endtask

    task automatic wait_idle(input bit step_first);
        int n = 0;
        if (step_first) begin
            @(negedge clk);
            sdi_valid = 1'b0;
        end
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_en(output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (en_out) seen = 1'b1;
            n++;
        end
        check("en_wait_timeout", int'(seen), 1);
    endtask

    // Monitor: every strobe must match the oldest outstanding frame in value and timing.
    exp_t mon;
    always @(negedge clk) begin
        if (!rstn) begin
            active  = 1'b0;
            en_prev = 1'b0;
        end else begin
            if (en_out && !en_prev) begin
                strobe_cnt++;
                check("strobe_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon = exp_q.pop_front();
                    check("d_out_at_rise", int'(d_out), int'(mon.word));
                    check("rise_cycle", cyc, mon.t_last + SC);
                    rise_cyc = cyc;
                    active   = 1'b1;
                end
            end
            if (!en_out && en_prev && active)
                check("en_len", cyc - rise_cyc, EC);
            if (done) begin
                check("done_expected", int'(active), 1);
                if (active) begin
                    check("done_cycle", cyc, mon.t_last + SC + EC + HC);
                    check("d_out_at_done", int'(d_out), int'(mon.word));
                    check("ready_at_done", int'(sdi_ready), 1);
                end
                active = 1'b0;
            end
            if (active) begin
                check("d_out_stable", int'(d_out), int'(mon.word));
                check("ready_low_busy", int'(sdi_ready), 0);
            end
            en_prev = en_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", tot_cnt);
        $fatal(1);
    end

    initial begin
        int  t1;
        int  t2;
        int  base;
        bit  seen;
        logic [W-1:0] w;

        rstn = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_d_out", int'(d_out), 0);
        check("rst_en_out", int'(en_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(sdi_ready), 1);

        // Partial frame then abort (coinciding with a valid bit): nothing is latched.
        base = strobe_cnt;
        send_bits(8'hB0, 5, 1'b0, t1);
        @(negedge clk);
        abort = 1'b1; sdi_valid = 1'b1; sdi = 1'b1;
        @(negedge clk);
        abort = 1'b0; sdi_valid = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_d_out", int'(d_out), 0);
        send_bits(8'hFF, W, 1'b0, t1);
        wait_idle(1'b1);
        check("abort_then_ff", int'(d_out), 'hFF);
        check("abort_one_strobe", strobe_cnt - base, 1);

        // Directed frame, valid held high.
        send_bits(8'hA5, W, 1'b0, t1);
        @(negedge clk);
        sdi_valid = 1'b0;
        check("a5_after_E", int'(d_out), 'hA5);
        check("a5_ready_low", int'(sdi_ready), 0);
        wait_idle(1'b0);

        // Backpressure on the valid line.
        send_bits(8'h3C, W, 1'b1, t1);
        wait_idle(1'b1);
        check("bp_d_out", int'(d_out), 'h3C);

        // Abort during the strobe is ignored.
        base = strobe_cnt;
        send_bits(8'h96, W, 1'b0, t1);
        @(negedge clk);
        sdi_valid = 1'b0;
        wait_en(seen);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        wait_idle(1'b0);
        check("strobe_abort_pulses", strobe_cnt - base, 1);
        check("strobe_abort_d_out", int'(d_out), 'h96);

        // Back-to-back frames with valid held high.
        base = strobe_cnt;
        send_bits(8'h01, W, 1'b0, t1);
        send_bits(8'h80, W, 1'b0, t2);
        wait_idle(1'b1);
        check("b2b_period", t2 - t1, W + SC + EC + HC);
        check("b2b_pulses", strobe_cnt - base, 2);

        // Random frames with random backpressure.
        for (int i = 0; i < 6; i++) begin
            w = W'($urandom);
            send_bits(w, W, 1'b1, t1);
            wait_idle(1'b1);
            check("rand_d_out", int'(d_out), int'(w));
        end

        // Reset in the second strobe cycle clears everything without a clock.
        send_bits(8'h5A, W, 1'b0, t1);
        @(negedge clk);
        sdi_valid = 1'b0;
        wait_en(seen);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_en_out", int'(en_out), 0);
        check("arst_d_out", int'(d_out), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("arst_ready", int'(sdi_ready), 1);
        check("arst_idle", int'(busy), 0);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/serial_latch_loader.md
# serial_latch_loader

Upstream driver for the team's transparent D latch bank. Accepts a serial bit stream over a valid/ready handshake, assembles a WIDTH-bit word MSB first, and presents it on `d_out`. It then runs a setup / strobe / hold sequence on `en_out` so the downstream latch only ever sees stable data while transparent. `d_out` and `en_out` connect directly to the latch D and enable inputs; both blocks share `rstn`.

## Interface
- `WIDTH`, default 8: word width; number of bits per frame; must be ≥ 1.
- `SETUP_CYC`, default 2: cycles `d_out` is stable before `en_out` rises; must be ≥ 1.
- `EN_CYC`, default 1: cycles `en_out` is held high; must be ≥ 1.
- `HOLD_CYC`, default 1: cycles `d_out` is stable after `en_out` falls; must be ≥ 1.

Ports:
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `sdi` in 1: serial data bit.
- `sdi_valid` in 1: `sdi` is valid.
- `sdi_ready` out 1: the block accepts a bit; a bit is taken when valid && ready at the edge.
- `abort` in 1: discards a partial frame.
- `d_out` out WIDTH: word presented to the latch D inputs.
- `en_out` out 1: latch enable strobe; registered, so glitch-free.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when the sequence completes.

## Operation
- FSM states: IDLE, SHIFT, SETUP, STROBE, HOLD.
- **IDLE**: `sdi_ready`=1. An accepted bit is shifted into `shreg` LSB, `bitcnt`=1, and the state moves to SHIFT. If WIDTH=1, the state goes straight to SETUP instead.
- **SHIFT**: `sdi_ready`=1. Each accepted bit does `shreg <= {shreg[WIDTH-2:0], sdi}` and `bitcnt++`.
  - On the WIDTH-th accepted bit: `d_out <= {shreg[WIDTH-2:0], sdi}`, the timer loads SETUP_CYC-1, and the state moves to SETUP.
- **abort** in IDLE or SHIFT: `bitcnt` is cleared, `shreg` is discarded, the state goes to IDLE, and `d_out` is unchanged. If abort coincides with an accepted bit, abort wins and the bit is dropped.
  - `abort` is ignored in SETUP, STROBE and HOLD; the latch sequence always completes.
- **SETUP**: `sdi_ready`=0, `en_out`=0. When the timer reaches 0: load EN_CYC-1, go to STROBE, `en_out<=1`.
- **STROBE**: `en_out`=1. When the timer reaches 0: load HOLD_CYC-1, go to HOLD, `en_out<=0`.
- **HOLD**: `en_out`=0. When the timer reaches 0: go to IDLE and `done<=1` for one cycle.
- `d_out` changes only on the SHIFT→SETUP (or IDLE→SETUP) transition. It is constant from SETUP entry until the next frame completes shifting.
- `bitcnt` is $clog2(WIDTH+1) bits wide. The timer is $clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC)) bits wide, minimum 1. There is no wrap: counts are compared for equality.
- Reset values:
  - state=IDLE, `d_out`=0, `en_out`=0, `done`=0, `busy`=0.
  - `sdi_ready`=1 after reset deassertion; `shreg`, `bitcnt` and the timer are 0.
- Reset asserted mid-frame or mid-strobe immediately forces `en_out`=0 and all of the above. The downstream latch clears on the same `rstn`.

## Timing
- Let edge E be the edge accepting bit WIDTH. `d_out` is valid after E.
- `en_out` rises after edge E+SETUP_CYC and falls after edge E+SETUP_CYC+EN_CYC.
- `done` is high for the cycle after edge E+SETUP_CYC+EN_CYC+HOLD_CYC. `sdi_ready` returns high in that same cycle.
- Minimum frame period is WIDTH+SETUP_CYC+EN_CYC+HOLD_CYC cycles with `sdi_valid` held high.
- `sdi_ready` and `busy` are decoded from the state register; `en_out`, `done` and `d_out` are flops.

## Structure
- Shared package `latch_loader_pkg`:
  - state encoding constants ST_IDLE=0, ST_SHIFT=1, ST_SETUP=2, ST_STROBE=3, ST_HOLD=4 (3 bits);
  - a width helper for the counter sizes.
- Sub-module `cycle_timer`: a loadable down-counter with a `zero` flag, shared by SETUP, STROBE and HOLD. The FSM and shift register live in the top module.

## Test plan
- WIDTH=8, SETUP=2, EN=3, HOLD=1; stream 0xA5 MSB first with `sdi_valid` held high.
  - `d_out`=0xA5 after edge 8.
  - `en_out` high for exactly 3 cycles starting 2 cycles later.
  - `done` pulses 1 cycle after `en_out` falls; `sdi_ready`=0 from edge 8 until `done`.
- Backpressure: toggle `sdi_valid` randomly while sending 0x3C → `d_out`=0x3C; no bit is lost or duplicated; the strobe timing is relative to the last accepted bit.
- Abort after 5 bits, then send 0xFF → the first partial frame never strobes; `d_out` goes 0x00→0xFF and there is exactly one `en_out` pulse.
- Assert `abort` during STROBE → ignored; `en_out` still lasts 3 cycles and `done` fires.
- Drop `rstn` in the 2nd STROBE cycle → `en_out`, `d_out`, `busy` and `done` are 0 immediately, without waiting for a clock; after release, the state is IDLE and `sdi_ready`=1.
- Back-to-back frames 0x01 then 0x80 → two `en_out` pulses; `d_out` stays stable across each pulse ±SETUP/HOLD; period is 14 cycles.
